// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : 8-line x 4-byte direct-mapped, write-back, write-allocate
//               data cache between a CPU and a block-wide data memory.
//               Address split: tag[7:5], index[4:2], offset[1:0].
// Revision    : 1.0  initial release
// ============================================================================
module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t      state;

    // Per-line status (reset) and storage (no reset needed: gated by valid).
    logic [7:0]  valid_bits;
    logic [7:0]  dirty_bits;
    logic [2:0]  tag_array  [0:7];
    logic [31:0] data_array [0:7];

    // Block the CPU asked for; survives a request dropped mid-miss.
    logic [5:0]  pending_block;

    logic [2:0]  req_tag;
    logic [2:0]  req_index;
    logic [1:0]  req_offset;
    logic        request;
    logic        hit;
    logic        store_en;
    logic        fill_en;
    logic [2:0]  fill_index;
    logic [2:0]  fill_tag;
    logic [31:0] line_word;
    logic [7:0]  line_byte;
    logic [31:0] store_word;

    assign req_tag    = ADDRESS[7:5];
    assign req_index  = ADDRESS[4:2];
    assign req_offset = ADDRESS[1:0];
    assign request    = READ | WRITE;

    assign line_word  = data_array[req_index];
    assign hit        = valid_bits[req_index] && (tag_array[req_index] == req_tag);

    // Only IDLE serves the CPU; every other state stalls a pending request.
    assign BUSYWAIT   = request && !((state == IDLE) && hit);
    assign READDATA   = (READ && hit) ? line_byte : 8'h00;

    // A store hit in IDLE writes in the same cycle; a write with READ also
    // high is still a store.
    assign store_en   = (state == IDLE) && WRITE && hit;

    // The fill completes on the first edge memory is not busy; the line
    // being filled is identified by the registered block address.
    assign fill_en    = (state == FETCH) && !mem_busywait;
    assign fill_index = mem_address[2:0];
    assign fill_tag   = mem_address[5:3];

    // Byte selected by the offset from the indexed line.
    always_comb begin
        line_byte = line_word[7:0];
        case (req_offset)
            2'd0: line_byte = line_word[7:0];
            2'd1: line_byte = line_word[15:8];
            2'd2: line_byte = line_word[23:16];
            2'd3: line_byte = line_word[31:24];
            default: line_byte = line_word[7:0];
        endcase
    end

    // Indexed line with the store byte merged at the offset.
    always_comb begin
        store_word = line_word;
        case (req_offset)
            2'd0: store_word[7:0]   = WRITEDATA;
            2'd1: store_word[15:8]  = WRITEDATA;
            2'd2: store_word[23:16] = WRITEDATA;
            2'd3: store_word[31:24] = WRITEDATA;
            default: store_word = line_word;
        endcase
    end

    // Tag and data storage: filled from memory or updated by a store hit.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_array[fill_index]  <= fill_tag;
            data_array[fill_index] <= mem_readdata;
        end else if (store_en) begin
            data_array[req_index]  <= store_word;
        end
    end

    // Controller FSM with registered memory-side outputs and line status.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            valid_bits    <= 8'h00;
            dirty_bits    <= 8'h00;
            pending_block <= 6'h00;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= 6'h00;
            mem_writedata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && !hit) begin
                        pending_block <= ADDRESS[7:2];
                        if (valid_bits[req_index] && dirty_bits[req_index]) begin
                            // Evict the dirty victim before fetching.
                            state         <= WRITEBACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {tag_array[req_index], req_index};
                            mem_writedata <= line_word;
                        end else begin
                            state       <= FETCH;
                            mem_read    <= 1'b1;
                            mem_address <= ADDRESS[7:2];
                        end
                    end else if (store_en) begin
                        dirty_bits[req_index] <= 1'b1;
                    end
                end

                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state         <= FETCH;
                        mem_write     <= 1'b0;
                        mem_read      <= 1'b1;
                        mem_address   <= pending_block;
                        mem_writedata <= 32'h0;
                    end
                end

                FETCH: begin
                    if (!mem_busywait) begin
                        state                  <= IDLE;
                        mem_read               <= 1'b0;
                        mem_address            <= 6'h00;
                        valid_bits[fill_index] <= 1'b1;
                        dirty_bits[fill_index] <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    mem_read    <= 1'b0;
                    mem_write   <= 1'b0;
                    mem_address <= 6'h00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Scoreboard bench for data_cache. A cache reference model
//               predicts load data and memory transfers; monitors compare.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_cache;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_ev_t;

    mem_ev_t     mem_q [$];
    logic [7:0]  rd_q  [$];

    // Memory seen by the DUT, and the model's own copy of memory.
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    // Reference cache contents.
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_data  [8];

    bit          resp_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Cache behaviour from first principles: miss => evict dirty victim,
    // fetch block; then apply the access unless the request was withdrawn.
    task automatic model_access(input bit is_wr, input logic [7:0] addr,
                                input logic [7:0] wd, input bit abort,
                                output bit was_hit);
        logic [2:0] idx;
        logic [2:0] t;
        int         off8;
        idx  = addr[4:2];
        t    = addr[7:5];
        off8 = int'(addr[1:0]) * 8;
        was_hit = m_valid[idx] && (m_tag[idx] == t);
        if (!was_hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                mem_q.push_back('{is_wr: 1'b1, addr: {m_tag[idx], idx}, data: m_data[idx]});
                ref_mem[{m_tag[idx], idx}] = m_data[idx];
            end
            mem_q.push_back('{is_wr: 1'b0, addr: addr[7:2], data: 32'h0});
            m_data[idx]  = ref_mem[addr[7:2]];
            m_tag[idx]   = t;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (!(abort && !was_hit)) begin
            if (is_wr) begin
                m_data[idx][off8 +: 8] = wd;
                m_dirty[idx] = 1'b1;
            end else begin
                rd_q.push_back(m_data[idx][off8 +: 8]);
            end
        end
    endtask

    // One CPU access, called at posedge+1; returns at posedge+1.
    task automatic do_access(input bit is_wr, input bit both, input logic [7:0] addr,
                             input logic [7:0] wd, input bit abort);
        bit hit;
        int cyc;
        model_access(is_wr, addr, wd, abort, hit);
        ADDRESS   = addr;
        WRITEDATA = wd;
        WRITE     = is_wr;
        READ      = !is_wr || both;
        cyc       = 0;
        @(negedge CLK);
        check("stall_on_entry", 32'(BUSYWAIT), 32'(!hit));
        if (abort && !hit) begin
            @(posedge CLK);
            #1;
            READ  = 1'b0;
            WRITE = 1'b0;
            while ((mem_q.size() != 0 || mem_read || mem_write) && cyc < 300) begin
                @(negedge CLK);
                cyc++;
            end
            if (cyc >= 300) fail_now("abort_timeout");
            @(posedge CLK);
            #1;
        end else begin
            while (BUSYWAIT && cyc < 300) begin
                @(negedge CLK);
                cyc++;
            end
            if (BUSYWAIT) fail_now("busywait_timeout");
            @(posedge CLK);
            #1;
            READ  = 1'b0;
            WRITE = 1'b0;
        end
    endtask

    // Memory responder: checks each transfer against the expected list,
    // then completes it after a random number of busy cycles.
    always begin : memory_responder
        bit wr;
        @(negedge CLK);
        if (resp_en && RESET && (mem_read || mem_write)) begin
            wr = mem_write;
            if (mem_q.size() == 0) begin
                fail_now("mem_unexpected_transfer");
            end else begin
                mem_ev_t e;
                e = mem_q.pop_front();
                check("mem_kind_is_write", 32'(wr), 32'(e.is_wr));
                check("mem_address", 32'(mem_address), 32'(e.addr));
                if (wr) check("mem_writedata", mem_writedata, e.data);
            end
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            if (wr) mem[mem_address] = mem_writedata;
            else    mem_readdata     = mem[mem_address];
            mem_busywait = 1'b0;
            @(posedge CLK);
            #1;
            mem_busywait = 1'b1;
        end
    end

    // Load monitor: a completed read pops the expected byte.
    always @(negedge CLK) begin
        if (RESET && READ && !WRITE) begin
            if (!BUSYWAIT) begin
                if (rd_q.size() == 0) fail_now("read_unexpected");
                else check("readdata", 32'(READDATA), 32'(rd_q.pop_front()));
            end else begin
                check("readdata_zero_on_miss", 32'(READDATA), 32'h0);
            end
        end
    end

    // Protocol monitor on the memory side.
    always @(negedge CLK) begin
        if (RESET && (mem_read || mem_write)) begin
            check("mem_rw_exclusive", 32'(mem_read && mem_write), 32'h0);
            if (READ || WRITE) check("busywait_while_busy", 32'(BUSYWAIT), 32'h1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cyc;
        RESET        = 1'b0;
        READ         = 1'b0;
        WRITE        = 1'b0;
        ADDRESS      = 8'h00;
        WRITEDATA    = 8'h00;
        mem_readdata = 32'h0;
        mem_busywait = 1'b1;
        resp_en      = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5]     = 32'hDDCCBBAA;
        ref_mem[5] = 32'hDDCCBBAA;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 3'd0;
            m_data[i]  = 32'h0;
        end

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_busywait",      32'(BUSYWAIT),      32'h0);
        check("reset_readdata",      32'(READDATA),      32'h0);
        check("reset_mem_read",      32'(mem_read),      32'h0);
        check("reset_mem_write",     32'(mem_write),     32'h0);
        check("reset_mem_address",   32'(mem_address),   32'h0);
        check("reset_mem_writedata", mem_writedata,      32'h0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Directed scenarios: cold read miss, store hit, dirty eviction,
        // clean write miss.
        do_access(1'b0, 1'b0, 8'h14, 8'h00, 1'b0);
        do_access(1'b1, 1'b0, 8'h16, 8'h5A, 1'b0);
        do_access(1'b0, 1'b0, 8'h16, 8'h00, 1'b0);
        do_access(1'b0, 1'b0, 8'hB4, 8'h00, 1'b0);
        do_access(1'b1, 1'b0, 8'h21, 8'h77, 1'b0);
        do_access(1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
        check("directed_mem_q_drained", 32'(mem_q.size()), 32'h0);

        // Reset pulsed during a fetch abandons it and invalidates the cache.
        resp_en = 1'b0;
        ADDRESS = 8'h14;
        READ    = 1'b1;
        cyc     = 0;
        while (!mem_read && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        check("rst_fetch_started", 32'(mem_read), 32'h1);
        check("rst_fetch_address", 32'(mem_address), 32'h05);
        #2;
        RESET = 1'b0;
        #1;
        check("rst_mem_read_drop",    32'(mem_read),    32'h0);
        check("rst_mem_write_drop",   32'(mem_write),   32'h0);
        check("rst_mem_address_zero", 32'(mem_address), 32'h0);
        READ = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        rd_q.delete();
        mem_q.delete();
        resp_en = 1'b1;
        @(posedge CLK);
        #1;
        do_access(1'b0, 1'b0, 8'hB4, 8'h00, 1'b0);

        // Randomized traffic: loads, stores, read+write, withdrawn misses.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a;
            logic [7:0] d;
            int         op;
            a  = 8'($urandom_range(0, 255));
            d  = 8'($urandom_range(0, 255));
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3, 4: do_access(1'b0, 1'b0, a, d, 1'b0);
                5, 6, 7:       do_access(1'b1, 1'b0, a, d, 1'b0);
                8:             do_access(1'b1, 1'b1, a, d, 1'b0);
                default:       do_access(1'($urandom_range(0, 1)), 1'b0, a, d, 1'b1);
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end

        repeat (5) @(negedge CLK);
        check("final_mem_q_empty", 32'(mem_q.size()), 32'h0);
        check("final_rd_q_empty",  32'(rd_q.size()),  32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
